// File: rtl/rs_pipelined_addsub.sv
// Segmented pipelined add/subtract: one SEG_WIDTH carry chain per stage.
// Optional signed-overflow tracking is built when RS_ADDSUB_OVF_EN is defined.
module rs_pipelined_addsub #(
    parameter int WIDTH     = 64,
    parameter int SEG_WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             co,
    output logic             ovf
);

    localparam int NSEG = (WIDTH + SEG_WIDTH - 1) / SEG_WIDTH;
    localparam int PW   = NSEG * SEG_WIDTH;

    logic                      en;
    logic [PW-1:0]             a_pad;
    logic [PW-1:0]             bb_pad;

    logic [NSEG:0][PW-1:0]     a_s;
    logic [NSEG:0][PW-1:0]     bb_s;
    logic [NSEG:0][PW-1:0]     y_s;
    logic [NSEG:0]             c_s;
    logic [NSEG:0]             v_s;

    logic [NSEG-1:0][PW-1:0]   a_q,  a_d;
    logic [NSEG-1:0][PW-1:0]   bb_q, bb_d;
    logic [NSEG-1:0][PW-1:0]   y_q,  y_d;
    logic [NSEG-1:0]           c_q,  c_d;
    logic [NSEG-1:0]           v_q,  v_d;

    logic [SEG_WIDTH:0]        seg_sum;
    logic [PW:0]               res;

    assign en       = !v_q[NSEG-1] || out_ready;
    assign in_ready = en;

    // Zero padding above WIDTH makes the last segment's carry land in bit WIDTH.
    always_comb begin
        a_pad              = '0;
        bb_pad             = '0;
        a_pad[WIDTH-1:0]   = a;
        bb_pad[WIDTH-1:0]  = sub ? ~b : b;
    end

    assign a_s  = {a_q, a_pad};
    assign bb_s = {bb_q, bb_pad};
    assign y_s  = {y_q, {PW{1'b0}}};
    assign c_s  = {c_q, ci};
    assign v_s  = {v_q, in_valid};

    always_comb begin
        a_d     = a_q;
        bb_d    = bb_q;
        y_d     = y_q;
        c_d     = c_q;
        v_d     = v_q;
        seg_sum = '0;
        for (int s = 0; s < NSEG; s++) begin
            seg_sum = {1'b0, a_s[s][s*SEG_WIDTH +: SEG_WIDTH]}
                    + {1'b0, bb_s[s][s*SEG_WIDTH +: SEG_WIDTH]}
                    + {{SEG_WIDTH{1'b0}}, c_s[s]};
            a_d[s]  = a_s[s];
            bb_d[s] = bb_s[s];
            y_d[s]  = y_s[s];
            y_d[s][s*SEG_WIDTH +: SEG_WIDTH] = seg_sum[SEG_WIDTH-1:0];
            c_d[s]  = seg_sum[SEG_WIDTH];
            v_d[s]  = v_s[s];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q  <= '0;
            bb_q <= '0;
            y_q  <= '0;
            c_q  <= '0;
            v_q  <= '0;
        end else if (en) begin
            a_q  <= a_d;
            bb_q <= bb_d;
            y_q  <= y_d;
            c_q  <= c_d;
            v_q  <= v_d;
        end
    end

`ifdef RS_ADDSUB_OVF_EN
    logic ovf_q, ovf_d;

    // Sign bits ride in the operand pipeline up to the final stage.
    always_comb begin
        ovf_d = (a_s[NSEG-1][WIDTH-1] == bb_s[NSEG-1][WIDTH-1])
             && (y_d[NSEG-1][WIDTH-1] != a_s[NSEG-1][WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (en) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign res       = {c_q[NSEG-1], y_q[NSEG-1]};
    assign y         = res[WIDTH-1:0];
    assign co        = res[WIDTH];
    assign out_valid = v_q[NSEG-1];

endmodule
